mul16_rr_scheduler: RTL

- Shares one multi-cycle 16-bit fixed-point multiplier (multiplier_16: I_VLD/I_M1/I_M2 in; O_VLD/O_MUL_BUSY/O_PRODUCT out) between NUM_REQ requesters.
- Arbitration is round-robin, with one operation outstanding at a time.
- Results return to the winning requester with a valid/ready handshake.
- A watchdog turns a missing multiplier result into an error response.
- Sits between attention-datapath clients (score/scale units) and the shared multiplier instance.

---
 rtl/mul16_sched_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/mul16_rr_scheduler.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mul16_sched_pkg.sv
// -----------------------------------------------------------------------------
// mul16_sched_pkg
//   Shared definitions for the mul16_rr_scheduler block:
//   - state_t        : scheduler FSM states
//   - DATA_W         : operand / product width of the shared multiplier
//   - Q_FRAC         : fractional bits of the Q2.13 format (informational; the
//                      scheduler forwards products untouched)
//   - timeout_cnt_w(): width of a counter able to hold 0 .. timeout-1
// -----------------------------------------------------------------------------
package mul16_sched_pkg;

  localparam int DATA_W = 16;
  localparam int Q_FRAC = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int timeout_cnt_w(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick. Starting at index ptr and wrapping
//   around, the first asserted request bit wins.
//
//   Ports:
//     req      in  NUM_REQ  request vector
//     ptr      in  ID_W     highest-priority index (must be < NUM_REQ)
//     gnt      out NUM_REQ  one-hot grant (all zero when nothing requests)
//     gnt_idx  out ID_W     binary index of the granted bit
//     any_gnt  out 1        at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any_gnt
);

  // One extra bit so ptr + offset cannot overflow before the wrap correction.
  localparam int SW = ID_W + 1;
  typedef logic [SW-1:0] sum_t;

  sum_t            sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + sum_t'(k);
      if (sum >= sum_t'(NUM_REQ)) begin
        sum = sum - sum_t'(NUM_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!any_gnt && req[idx]) begin
        any_gnt   = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/mul16_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mul16_rr_scheduler
//   Shares one multi-cycle 16-bit fixed-point multiplier between NUM_REQ
//   clients. Round-robin arbitration, one operation in flight, valid/ready
//   response per client and a watchdog that converts a missing multiplier
//   result into an error response.
//
//   Ports:
//     I_CLK          in   1            clock
//     I_RST_N        in   1            asynchronous active-low reset
//     I_REQ_VLD      in   NUM_REQ      per-requester request valid
//     I_REQ_M1       in   NUM_REQ*16   multiplicands, slice i = [16i+15:16i]
//     I_REQ_M2       in   NUM_REQ*16   multipliers,   slice i = [16i+15:16i]
//     O_REQ_RDY      out  NUM_REQ      one-hot accept strobe (combinational)
//     O_RSP_VLD      out  NUM_REQ      one-hot response valid
//     O_RSP_DATA     out  16           product (Q2.13, forwarded unmodified)
//     O_RSP_ERR      out  1            1 = watchdog timeout response
//     I_RSP_RDY      in   NUM_REQ      per-requester response ready
//     O_MUL_VLD      out  1            multiplier start strobe
//     O_MUL_M1/M2    out  16           multiplier operands
//     I_MUL_VLD      in   1            multiplier result valid
//     I_MUL_BUSY     in   1            multiplier busy
//     I_MUL_PRODUCT  in   16           multiplier result
//     O_BUSY         out  1            scheduler not idle
//     O_OWNER        out  ID_W         index of current owner
// -----------------------------------------------------------------------------
module mul16_rr_scheduler
  import mul16_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                      I_CLK,
  input  logic                      I_RST_N,
  input  logic [NUM_REQ-1:0]        I_REQ_VLD,
  input  logic [NUM_REQ*DATA_W-1:0] I_REQ_M1,
  input  logic [NUM_REQ*DATA_W-1:0] I_REQ_M2,
  output logic [NUM_REQ-1:0]        O_REQ_RDY,
  output logic [NUM_REQ-1:0]        O_RSP_VLD,
  output logic [DATA_W-1:0]         O_RSP_DATA,
  output logic                      O_RSP_ERR,
  input  logic [NUM_REQ-1:0]        I_RSP_RDY,
  output logic                      O_MUL_VLD,
  output logic [DATA_W-1:0]         O_MUL_M1,
  output logic [DATA_W-1:0]         O_MUL_M2,
  input  logic                      I_MUL_VLD,
  input  logic                      I_MUL_BUSY,
  input  logic [DATA_W-1:0]         I_MUL_PRODUCT,
  output logic                      O_BUSY,
  output logic [ID_W-1:0]           O_OWNER
);

  localparam int              CNT_W   = timeout_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]   wd_cnt;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic               accept;
  logic [ID_W-1:0]    ptr_nxt;

  logic signed [DATA_W-1:0] win_m1;
  logic signed [DATA_W-1:0] win_m2;
  logic [NUM_REQ-1:0] owner_oh;
  logic               owner_rdy;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (I_REQ_VLD),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_gnt (arb_any)
  );

  // A busy multiplier blocks arbitration entirely so the pointer holds.
  assign accept    = (state == IDLE) && arb_any && !I_MUL_BUSY;
  assign O_REQ_RDY = accept ? arb_gnt : '0;
  assign O_BUSY    = (state != IDLE);

  assign ptr_nxt = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);

  // Grant-qualified AND-OR mux: only the winner's operand bits reach the
  // operand registers.
  always_comb begin
    win_m1 = '0;
    win_m2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        win_m1 = win_m1 | I_REQ_M1[i*DATA_W +: DATA_W];
        win_m2 = win_m2 | I_REQ_M2[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (O_OWNER == ID_W'(i)) begin
        owner_oh[i] = 1'b1;
      end
    end
  end

  // Ready bits of non-owners are masked off.
  assign owner_rdy = |(I_RSP_RDY & owner_oh);

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      wd_cnt     <= '0;
      O_OWNER    <= '0;
      O_MUL_VLD  <= 1'b0;
      O_MUL_M1   <= '0;
      O_MUL_M2   <= '0;
      O_RSP_VLD  <= '0;
      O_RSP_DATA <= '0;
      O_RSP_ERR  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            O_MUL_M1  <= win_m1;
            O_MUL_M2  <= win_m2;
            O_OWNER   <= arb_idx;
            rr_ptr    <= ptr_nxt;
            O_MUL_VLD <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          O_MUL_VLD <= 1'b0;
          O_MUL_M1  <= '0;
          O_MUL_M2  <= '0;
          wd_cnt    <= '0;
          state     <= WAIT;
        end

        WAIT: begin
          // A product arriving on the timeout cycle still wins.
          if (I_MUL_VLD) begin
            O_RSP_DATA <= I_MUL_PRODUCT;
            O_RSP_ERR  <= 1'b0;
            O_RSP_VLD  <= owner_oh;
            state      <= RESP;
          end else if (wd_cnt == CNT_MAX) begin
            O_RSP_DATA <= '0;
            O_RSP_ERR  <= 1'b1;
            O_RSP_VLD  <= owner_oh;
            state      <= RESP;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          if (owner_rdy) begin
            O_RSP_VLD  <= '0;
            O_RSP_DATA <= '0;
            O_RSP_ERR  <= 1'b0;
            wd_cnt     <= '0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
